// File: rtl/cotm32_pipeline_pkg.sv
// Shared pipeline-control types: controller state, redirect target encoding and
// the bundled stall/flush vector handed to the pipeline registers.
package cotm32_pipeline_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        TRAP_FLUSH = 2'd2,
        REDIRECT   = 2'd3
    } pipe_ctrl_state_t;

    localparam logic REDIRECT_SEL_MTVEC = 1'b0;
    localparam logic REDIRECT_SEL_MEPC  = 1'b1;

    typedef struct packed {
        logic stall_pc;
        logic stall_ifid;
        logic stall_idex;
        logic stall_exmem;
        logic flush_ifid;
        logic flush_idex;
        logic flush_exmem;
        logic flush_memwb;
    } pipe_ctrl_t;

    // Canned patterns; a register is never stalled and flushed in the same pattern.
    localparam pipe_ctrl_t PIPE_CTRL_IDLE     = pipe_ctrl_t'(8'b0000_0000);
    localparam pipe_ctrl_t PIPE_CTRL_RESET    = pipe_ctrl_t'(8'b0000_1111);
    localparam pipe_ctrl_t PIPE_CTRL_LOADUSE  = pipe_ctrl_t'(8'b1100_0100);
    localparam pipe_ctrl_t PIPE_CTRL_MEMWAIT  = pipe_ctrl_t'(8'b1111_0001);
    localparam pipe_ctrl_t PIPE_CTRL_TRAP     = pipe_ctrl_t'(8'b1000_1110);
    localparam pipe_ctrl_t PIPE_CTRL_REDIRECT = pipe_ctrl_t'(8'b0000_1000);

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Stage-status inputs and stall/flush/CSR outputs of the pipeline controller.
interface pipeline_ctrl_if;
    logic [4:0] i_id_rs1;
    logic [4:0] i_id_rs2;
    logic       i_id_uses_rs1;
    logic       i_id_uses_rs2;
    logic       i_ex_valid;
    logic       i_ex_is_load;
    logic [4:0] i_ex_rd;
    logic       i_mem_valid;
    logic       i_mem_trap;
    logic       i_mem_mret;
    logic       i_mem_busy;
    logic       o_stall_ifid;
    logic       o_stall_idex;
    logic       o_stall_exmem;
    logic       o_stall_pc;
    logic       o_flush_ifid;
    logic       o_flush_idex;
    logic       o_flush_exmem;
    logic       o_flush_memwb;
    logic       o_trap_take;
    logic       o_mret_take;
    logic       o_redirect;
    logic       o_redirect_sel;
    logic       o_mem_timeout;

    modport master (
        input  i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
        input  i_ex_valid, i_ex_is_load, i_ex_rd,
        input  i_mem_valid, i_mem_trap, i_mem_mret, i_mem_busy,
        output o_stall_ifid, o_stall_idex, o_stall_exmem, o_stall_pc,
        output o_flush_ifid, o_flush_idex, o_flush_exmem, o_flush_memwb,
        output o_trap_take, o_mret_take, o_redirect, o_redirect_sel, o_mem_timeout
    );

    modport slave (
        output i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
        output i_ex_valid, i_ex_is_load, i_ex_rd,
        output i_mem_valid, i_mem_trap, i_mem_mret, i_mem_busy,
        input  o_stall_ifid, o_stall_idex, o_stall_exmem, o_stall_pc,
        input  o_flush_ifid, o_flush_idex, o_flush_exmem, o_flush_memwb,
        input  o_trap_take, o_mret_take, o_redirect, o_redirect_sel, o_mem_timeout
    );
endinterface

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    output logic       hazard
);
    logic rs1_hit_s;
    logic rs2_hit_s;

    // x0 never carries a dependency, so rd==0 cannot hazard.
    assign rs1_hit_s = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit_s = id_uses_rs2 && (id_rs2 == ex_rd);
    assign hazard    = ex_valid && ex_is_load && (ex_rd != 5'd0) && (rs1_hit_s || rs2_hit_s);
endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: load-use bubbles, data-memory waits with
// timeout, and trap/mret entry (drain, CSR commit window, PC redirect).
module pipeline_ctrl
    import cotm32_pipeline_pkg::*;
#(
    parameter int TRAP_LATENCY = 1,
    parameter int MEM_TIMEOUT  = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    pipeline_ctrl_if.master bus
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int TRAP_W = $clog2(TRAP_LATENCY + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [TRAP_W-1:0] TRAP_LAST = TRAP_W'(TRAP_LATENCY - 1);

    pipe_ctrl_state_t  state_r, state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r, wait_cnt_nxt_s;
    logic [TRAP_W-1:0] trap_cnt_r, trap_cnt_nxt_s;
    logic              sel_r, sel_nxt_s;
    pipe_ctrl_t        ctrl_s, out_ctrl_s;
    logic              trap_take_s, mret_take_s, redirect_s, timeout_s;
    logic              out_trap_take_s, out_mret_take_s, out_redirect_s;
    logic              out_sel_s, out_timeout_s;
    logic              load_use_s;

    load_use_detect u_load_use (
        .id_rs1      (bus.i_id_rs1),
        .id_rs2      (bus.i_id_rs2),
        .id_uses_rs1 (bus.i_id_uses_rs1),
        .id_uses_rs2 (bus.i_id_uses_rs2),
        .ex_valid    (bus.i_ex_valid),
        .ex_is_load  (bus.i_ex_is_load),
        .ex_rd       (bus.i_ex_rd),
        .hazard      (load_use_s)
    );

    // Next-state and per-cycle stall/flush decision.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        trap_cnt_nxt_s = trap_cnt_r;
        sel_nxt_s      = sel_r;
        ctrl_s         = PIPE_CTRL_IDLE;
        trap_take_s    = 1'b0;
        mret_take_s    = 1'b0;
        redirect_s     = 1'b0;
        timeout_s      = 1'b0;
        case (state_r)
            RUN: begin
                if (bus.i_mem_valid && (bus.i_mem_trap || bus.i_mem_mret)) begin
                    trap_take_s    = bus.i_mem_trap;
                    mret_take_s    = ~bus.i_mem_trap;
                    sel_nxt_s      = bus.i_mem_trap ? REDIRECT_SEL_MTVEC : REDIRECT_SEL_MEPC;
                    ctrl_s         = PIPE_CTRL_TRAP;
                    trap_cnt_nxt_s = TRAP_W'(0);
                    state_nxt_s    = TRAP_FLUSH;
                end else if (bus.i_mem_valid && bus.i_mem_busy) begin
                    ctrl_s         = PIPE_CTRL_MEMWAIT;
                    wait_cnt_nxt_s = WAIT_W'(1);
                    state_nxt_s    = MEM_WAIT;
                end else if (load_use_s) begin
                    ctrl_s = PIPE_CTRL_LOADUSE;
                end else begin
                    ctrl_s = PIPE_CTRL_IDLE;
                end
            end
            MEM_WAIT: begin
                // Trap flags wait until RUN; the release cycle drives nothing.
                if (!bus.i_mem_busy) begin
                    wait_cnt_nxt_s = WAIT_W'(0);
                    state_nxt_s    = RUN;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    timeout_s      = 1'b1;
                    wait_cnt_nxt_s = WAIT_W'(0);
                    state_nxt_s    = RUN;
                end else begin
                    ctrl_s         = PIPE_CTRL_MEMWAIT;
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            TRAP_FLUSH: begin
                ctrl_s = PIPE_CTRL_TRAP;
                if (trap_cnt_r == TRAP_LAST) begin
                    trap_cnt_nxt_s = TRAP_W'(0);
                    state_nxt_s    = REDIRECT;
                end else begin
                    trap_cnt_nxt_s = trap_cnt_r + TRAP_W'(1);
                end
            end
            REDIRECT: begin
                ctrl_s      = PIPE_CTRL_REDIRECT;
                redirect_s  = 1'b1;
                state_nxt_s = RUN;
            end
            default: begin
                wait_cnt_nxt_s = WAIT_W'(0);
                trap_cnt_nxt_s = TRAP_W'(0);
                state_nxt_s    = RUN;
            end
        endcase
    end

    // State, counters and latched redirect target.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= RUN;
            wait_cnt_r <= WAIT_W'(0);
            trap_cnt_r <= TRAP_W'(0);
            sel_r      <= REDIRECT_SEL_MTVEC;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            trap_cnt_r <= trap_cnt_nxt_s;
            sel_r      <= sel_nxt_s;
        end
    end

    // During reset every register is flushed and no pulse escapes.
    always_comb begin
        if (!i_rst_n) begin
            out_ctrl_s      = PIPE_CTRL_RESET;
            out_trap_take_s = 1'b0;
            out_mret_take_s = 1'b0;
            out_redirect_s  = 1'b0;
            out_sel_s       = 1'b0;
            out_timeout_s   = 1'b0;
        end else begin
            out_ctrl_s      = ctrl_s;
            out_trap_take_s = trap_take_s;
            out_mret_take_s = mret_take_s;
            out_redirect_s  = redirect_s;
            out_sel_s       = redirect_s & sel_r;
            out_timeout_s   = timeout_s;
        end
    end

    assign bus.o_stall_pc     = out_ctrl_s.stall_pc;
    assign bus.o_stall_ifid   = out_ctrl_s.stall_ifid;
    assign bus.o_stall_idex   = out_ctrl_s.stall_idex;
    assign bus.o_stall_exmem  = out_ctrl_s.stall_exmem;
    assign bus.o_flush_ifid   = out_ctrl_s.flush_ifid;
    assign bus.o_flush_idex   = out_ctrl_s.flush_idex;
    assign bus.o_flush_exmem  = out_ctrl_s.flush_exmem;
    assign bus.o_flush_memwb  = out_ctrl_s.flush_memwb;
    assign bus.o_trap_take    = out_trap_take_s;
    assign bus.o_mret_take    = out_mret_take_s;
    assign bus.o_redirect     = out_redirect_s;
    assign bus.o_redirect_sel = out_sel_s;
    assign bus.o_mem_timeout  = out_timeout_s;
endmodule
